// File: rtl/neuro_seq_ctrl.sv
// Neuron tile array sequencer: config chain load, array reset, run decay clocks.
// Define NEURO_SEQ_READBACK_EN to build the chain-tail readback port.
module neuro_seq_ctrl #(
  parameter int N_NEURONS       = 9,
  parameter int BITS_PER_NEURON = 17,
  parameter int RST_CYCLES      = 2,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       start,
  input  logic       stop,
  output logic       conf_en,
  output logic       bs_out,
  output logic       nn_reset,
  output logic [7:0] dbus,
  output logic       in_en,
  output logic       cfg_done,
  output logic       load_abort,
  output logic [1:0] state
`ifdef NEURO_SEQ_READBACK_EN
  ,
  input  logic       bs_ret,
  output logic [7:0] rb_data,
  output logic       rb_valid
`endif
);

  localparam int CHAIN_LEN = N_NEURONS * BITS_PER_NEURON;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [RW-1:0] CLR_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       buf_q;
  logic             buf_full;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] bit_cnt;
  logic [RW-1:0]    clr_cnt;
  logic [CNT_W-1:0] rc_q;
  logic [CNT_W-1:0] rc_nx;
  logic [7:0]       dbus_nx;
  logic             run_and;
  logic             in_load;
  logic             shift;
  logic             done_now;
  logic             accept;

  assign in_load  = (state_q == S_LOAD);
  assign shift    = in_load && buf_full;
  assign done_now = shift && (bit_cnt == LAST_BIT);
  assign cfg_ready = in_load && !stop && !done_now
                   && (!buf_full || bit_idx == 3'd7);
  assign accept   = cfg_valid && cfg_ready;

  assign conf_en  = shift;
  assign bs_out   = shift && buf_q[3'd7 - bit_idx];
  assign nn_reset = (state_q == S_CLEAR);
  assign in_en    = (state_q == S_RUN);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) state_d = S_LOAD;
        else if (start) state_d = S_CLEAR;
      end
      S_LOAD: begin
        if (stop || done_now) state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (stop) state_d = S_IDLE;
        else if (clr_cnt == CLR_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // dbus is computed from the counter value it will sit beside
  always_comb begin
    rc_nx   = (state_q == S_RUN) ? rc_q + CNT_W'(1) : '0;
    dbus_nx = '0;
    run_and = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_and    = run_and & rc_nx[i];
      dbus_nx[i] = run_and;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full   <= 1'b0;
      bit_idx    <= '0;
      bit_cnt    <= '0;
      cfg_done   <= 1'b0;
      load_abort <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_start) begin
            cfg_done   <= 1'b0;
            load_abort <= 1'b0;
            bit_cnt    <= '0;
            buf_full   <= 1'b0;
            bit_idx    <= '0;
          end
        end
        S_LOAD: begin
          if (stop || done_now) begin
            buf_full <= 1'b0;
            if (done_now) cfg_done <= 1'b1;
            else          load_abort <= 1'b1;
          end else if (accept) begin
            buf_q    <= cfg_data;
            buf_full <= 1'b1;
            bit_idx  <= '0;
          end else if (shift) begin
            if (bit_idx == 3'd7) buf_full <= 1'b0;
            else                 bit_idx <= bit_idx + 3'd1;
          end
          if (shift) bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: begin
          buf_full <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      rc_q    <= '0;
      dbus    <= '0;
    end else begin
      clr_cnt <= (state_q == S_CLEAR) ? clr_cnt + RW'(1) : '0;
      if (state_d == S_RUN) begin
        rc_q <= rc_nx;
        dbus <= dbus_nx;
      end else begin
        rc_q <= '0;
        dbus <= '0;
      end
    end
  end

`ifdef NEURO_SEQ_READBACK_EN
  logic [7:0] rb_sr;
  logic [7:0] rb_sr_nx;
  logic [3:0] rb_cnt;
  logic [3:0] rb_cnt_nx;
  logic       load_end;

  assign rb_sr_nx  = shift ? {rb_sr[6:0], bs_ret} : rb_sr;
  assign rb_cnt_nx = rb_cnt + {3'b000, shift};
  assign load_end  = in_load && (stop || done_now);

  // a partial last byte is left-aligned so bit 7 is always the first bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_sr    <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state_q == S_IDLE && load_start) begin
        rb_sr  <= '0;
        rb_cnt <= '0;
      end else if (in_load) begin
        if (rb_cnt_nx == 4'd8) begin
          rb_data  <= rb_sr_nx;
          rb_valid <= 1'b1;
          rb_sr    <= '0;
          rb_cnt   <= '0;
        end else if (load_end && rb_cnt_nx != 4'd0) begin
          rb_data  <= rb_sr_nx << (4'd8 - rb_cnt_nx);
          rb_valid <= 1'b1;
          rb_sr    <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_sr  <= rb_sr_nx;
          rb_cnt <= rb_cnt_nx;
        end
      end
    end
  end
`endif

endmodule
